// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared states, owner codes and byte-lane helper for the memory arbiter
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;
  localparam int BEATS_PER_WORD = 4;
  // Big-endian lane: beat 0 carries bits [31:24].
  function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] k);
    return w[31-8*int'(k) -: 8];
  endfunction
endpackage

// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: fetch port, data port and 8-bit pin bus of the memory arbiter
// slave modport: arbiter view (requests and bus_rdata in; acks, read data, bus_* and status out)
// master modport: core/memory view, the mirror image
interface mips_mem_arbiter_if #(parameter int ADDR_W = 8);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic              dm_byte;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_ack;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_we;
  logic [7:0]        bus_rdata;
  logic              busy;
  logic              grant_dm;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, bus_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, bus_addr, bus_wdata, bus_we, busy, grant_dm
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, bus_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, bus_addr, bus_wdata, bus_we, busy, grant_dm
  );
endinterface

// File: rtl/mips_mem_arbiter_timer.sv
// mem_beat_timer: per-beat wait counter and beat index for one transaction
// in: start (grant), active (in BEAT), size (1=single byte beat); out: beat, beat_last, xfer_done
import mips_mem_pkg::*;
module mem_beat_timer #(parameter int WAIT = 0) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       active,
  input  logic       size,
  output logic [1:0] beat,
  output logic       beat_last,
  output logic       xfer_done
);
  localparam logic [3:0] WL = 4'(WAIT);
  logic [3:0] wcnt_q, wcnt_d;
  logic [1:0] beat_q, beat_d;
  always_comb begin
    beat_last = active && wcnt_q == WL;
    xfer_done = beat_last && (size || beat_q == 2'(BEATS_PER_WORD - 1));
    wcnt_d = (start || beat_last) ? 4'd0 : active ? wcnt_q + 4'd1 : wcnt_q;
    beat_d = start ? 2'd0 : beat_last ? beat_q + 2'd1 : beat_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      beat_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      beat_q <= beat_d;
    end
  end
  assign beat = beat_q;
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares the 8-bit pin bus between instruction fetch and data ports
// ports: clk, rst (sync, active-high), b (mips_mem_arbiter_if.slave: fetch/data ports, pin bus, busy, grant_dm)
// ARB_RR_EN defined: round-robin on contention; undefined: data port has fixed priority
import mips_mem_pkg::*;
module mips_mem_arbiter #(
  parameter int WAIT   = 0,
  parameter int ADDR_W = 8
) (
  input logic              clk,
  input logic              rst,
  mips_mem_arbiter_if.slave b
);
  state_t            state_q, state_d;
  logic              own_q, own_d, we_q, we_d, byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic [23:0]       data_q, data_d;
  logic [31:0]       rd_word;
  logic [1:0]        beat;
  logic              pick, start, beat_last, xfer_done;
  mem_beat_timer #(.WAIT(WAIT)) u_timer (
    .clk(clk), .rst(rst), .start(start), .active(state_q == BEAT), .size(byte_q),
    .beat(beat), .beat_last(beat_last), .xfer_done(xfer_done)
  );
  always_comb begin
`ifdef ARB_RR_EN
    pick = b.dm_req && (!b.if_req || own_q == OWN_IF);
`else
    pick = b.dm_req;
`endif
    start = state_q == IDLE && (b.if_req || b.dm_req);
    rd_word = {data_q, b.bus_rdata};
    state_d = state_q;
    own_d = own_q;
    we_d = we_q;
    byte_d = byte_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    data_d = data_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    // Word addresses are aligned at grant so the beat index can simply be OR-ed in (no carry).
    // Byte store data is parked in the top lane so beat 0 picks it up.
    if (start) begin
      state_d = BEAT;
      own_d = pick;
      we_d = pick && b.dm_we;
      byte_d = pick && b.dm_byte;
      addr_d = pick ? (b.dm_byte ? b.dm_addr : {b.dm_addr[ADDR_W-1:2], 2'b00})
                    : {b.if_addr[ADDR_W-1:2], 2'b00};
      wdata_d = b.dm_byte ? {b.dm_wdata[7:0], 24'h0} : b.dm_wdata;
      data_d = '0;
    end
    if (beat_last && !we_q) data_d = rd_word[23:0];
    if (xfer_done) begin
      state_d = DONE;
      if (!we_q && own_q == OWN_DM) dm_rdata_d = rd_word;
      if (!we_q && own_q == OWN_IF) if_rdata_d = rd_word;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      own_q <= OWN_IF;
      we_q <= 1'b0;
      byte_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      data_q <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      we_q <= we_d;
      byte_q <= byte_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      data_q <= data_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end
  assign b.bus_addr = state_q == BEAT ? addr_q | ADDR_W'(beat) : '0;
  assign b.bus_wdata = (state_q == BEAT && we_q) ? lane_sel(wdata_q, beat) : 8'h0;
  assign b.bus_we = state_q == BEAT && we_q;
  assign b.if_ack = state_q == DONE && own_q == OWN_IF;
  assign b.dm_ack = state_q == DONE && own_q == OWN_DM;
  assign b.if_rdata = if_rdata_q;
  assign b.dm_rdata = dm_rdata_q;
  assign b.busy = state_q != IDLE;
  assign b.grant_dm = own_q;
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares the SoC's single 8-bit external memory pin bus between the MIPS core's instruction-fetch port and data (load/store) port.
- Sequences each 32-bit word access as four big-endian byte beats, and each byte access as one beat.
- Returns assembled read data with a one-cycle ack.
- Sits between the core and the ui_in/uo_out/uio_out pin mapping at the top level.

Parameters:
- WAIT, 0: extra cycles each beat is held before data is sampled/committed (0..15).
- ADDR_W, 8: external byte address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  instruction fetch request (word read)
- if_addr  in  ADDR_W  fetch byte address (bits [1:0] ignored)
- if_rdata  out  32  fetched word, valid when if_ack=1
- if_ack  out  1  one-cycle completion pulse
- dm_req  in  1  data request
- dm_we  in  1  1=store, 0=load
- dm_byte  in  1  1=byte access, 0=word access
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  32  store data (byte store uses [7:0])
- dm_rdata  out  32  load data (byte load zero-extended), valid when dm_ack=1
- dm_ack  out  1  one-cycle completion pulse
- bus_addr  out  ADDR_W  external byte address
- bus_wdata  out  8  external write byte
- bus_we  out  1  external write strobe
- bus_rdata  in  8  external read byte
- busy  out  1  transaction in progress (state != IDLE)
- grant_dm  out  1  current/last grant owner: 1=data, 0=fetch

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: all outputs 0; state IDLE; beat counter 0; wait counter 0.
- Reset mid-transaction: next cycle is IDLE. No ack is issued. bus_we=0. Partially assembled data is discarded.
- States:
  - IDLE: bus_addr=0, bus_wdata=0, bus_we=0. If any request is present, latch owner, address, we, size and wdata, then go to BEAT.
  - BEAT: drive beat k. Stay 1+WAIT cycles. In the last cycle of a beat, sample bus_rdata on reads, or hold bus_we=1 on writes (bus_we=1 for the whole beat).
  - BEAT exit: after the final beat (k=3 word, k=0 byte), go to DONE.
  - DONE: pulse the owner's ack for one cycle; rdata is stable from this cycle until the next ack. Then go to IDLE.
- Word beat k: bus_addr = {addr[ADDR_W-1:2], k[1:0]}. Beat 0 carries bits [31:24] (big-endian). Write byte k = wdata[31-8k -: 8].
- Byte beat: bus_addr = dm_addr unchanged. Write byte = dm_wdata[7:0]. Read gives rdata = {24'b0, byte}.
- Latency from req sampled in IDLE (cycle 0):
  - Word: ack in cycle 5+4*WAIT.
  - Byte: ack in cycle 2+WAIT.
- Arbitration (default): fixed priority, data over fetch, evaluated only in IDLE. Simultaneous requests grant dm.
- Handshake:
  - Requester holds req/addr/data stable until its ack.
  - Inputs are latched at grant, so changes after grant are ignored. A withdrawn req still completes and acks.
  - req still high in the cycle after ack is treated as a new request.
  - Non-granted req waits with no ack.
- Address wrap: word at 0xFC touches 0xFC..0xFF only. There is no carry into the next word.
- Store ack: dm_rdata is unchanged on store acks.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests in IDLE, grant the port that did NOT own the previous transaction; the first contention after reset grants dm.
- Undefined: fixed data-over-fetch priority as above.
- In both cases a lone requester is granted immediately.

Decomposition:
- Package mips_mem_pkg:
  - state enum {IDLE, BEAT, DONE}
  - owner constants OWN_IF=0, OWN_DM=1
  - BEATS_PER_WORD=4
  - byte-lane select function (beat -> wdata slice)
- Sub-module mem_beat_timer: counts WAIT cycles and beats. Inputs start/size; outputs beat index, beat_last, xfer_done. Main block keeps FSM, arbiter and data assembly.

Test Plan:
- Word load, WAIT=0: dm_req, dm_addr=0x10, memory 0x10..0x13=AA BB CC DD -> bus_addr 10,11,12,13 in cycles 1-4; dm_ack in cycle 5; dm_rdata=0xAABBCCDD.
- Word store: dm_we=1, dm_addr=0x23, dm_wdata=0x11223344 -> bus_addr 20..23, bus_wdata 11,22,33,44, bus_we=1 each beat; dm_ack cycle 5.
- Byte load, WAIT=2: dm_byte=1, dm_addr=0x41, memory=0x9C -> single beat held 3 cycles; dm_ack cycle 4; dm_rdata=0x0000009C.
- Contention: if_req and dm_req both high in IDLE -> dm served first, if_ack follows dm_ack after one IDLE cycle. With ARB_RR_EN and prior owner dm -> fetch served first.
- Reset mid-word: rst=1 during beat 2 -> next cycle busy=0, bus_we=0, no ack. Request re-issued after reset completes normally.
- Back-to-back fetch: if_req held high across if_ack -> second fetch starts after one IDLE cycle; both acks carry correct data.
